// File: rtl/lite16_uart_tx_if.sv
// CPU data-bus view of the lite16 UART TX peripheral: store strobe, address, data and status readback.
interface lite16_uart_tx_if;
   logic        wr_en;
   logic [15:0] addr;
   logic [15:0] wr_data;
   logic [15:0] rd_data;

   modport master (output wr_en, output addr, output wr_data, input rd_data);
   modport slave  (input wr_en, input addr, input wr_data, output rd_data);
endinterface

// File: rtl/lite16_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: CPU stores to BASE_ADDR feed a byte FIFO drained onto tx.
// BASE_ADDR+1 holds the status word {overflow, fifo_full, busy}; writing bit 2 clears overflow.
module lite16_uart_tx #(
   parameter int unsigned CLK_DIV    = 16,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter logic [15:0] BASE_ADDR  = 16'hFF00
) (
   input  logic            clk,
   input  logic            rst,
   lite16_uart_tx_if.slave bus,
   output logic            tx,
   output logic            busy,
   output logic            fifo_full
);
   localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam logic [15:0]      CTRL_ADDR = BASE_ADDR + 16'd1;
   localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t           state;
   logic [7:0]       mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic             overflow;
   logic [7:0]       shift_reg;
   logic [2:0]       bit_cnt;
   logic [DIV_W-1:0] div_cnt;

   logic push_req;
   logic push_ok;
   logic pop;
   logic clr_ovf;
   logic div_done;
   logic fifo_nonempty;
   logic unused_bits;

   assign push_req      = bus.wr_en && (bus.addr == BASE_ADDR);
   assign clr_ovf       = bus.wr_en && (bus.addr == CTRL_ADDR) && bus.wr_data[2];
   assign fifo_full     = (count == CNT_FULL);
   assign fifo_nonempty = (count != '0);
   assign push_ok       = push_req && !fifo_full;
   assign div_done      = (div_cnt == DIV_LAST);
   // A pop happens from IDLE, or at the last cycle of STOP so frames chain without a gap.
   assign pop           = fifo_nonempty && ((state == IDLE) || ((state == STOP) && div_done));
   assign busy          = (state != IDLE) || fifo_nonempty;
   assign bus.rd_data   = (bus.addr == CTRL_ADDR) ? {13'b0, overflow, fifo_full, busy} : 16'h0000;
   assign unused_bits   = ^bus.wr_data[15:8];

   // FIFO pointers, occupancy and sticky overflow; a drop when full wins over a same-cycle clear.
   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
         count <= count + CNT_W'(push_ok) - CNT_W'(pop);
         if (push_req && fifo_full) overflow <= 1'b1;
         else if (clr_ovf)          overflow <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= bus.wr_data[7:0];
   end

   // Frame sequencer; tx is registered and always holds the level of the current bit period.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= IDLE;
         tx        <= 1'b1;
         shift_reg <= '0;
         bit_cnt   <= '0;
         div_cnt   <= '0;
      end else begin
         case (state)
            IDLE: begin
               tx <= 1'b1;
               if (pop) begin
                  shift_reg <= mem[rd_ptr];
                  div_cnt   <= '0;
                  tx        <= 1'b0;
                  state     <= START;
               end
            end
            START: begin
               if (div_done) begin
                  div_cnt <= '0;
                  bit_cnt <= '0;
                  tx      <= shift_reg[0];
                  state   <= DATA;
               end else begin
                  div_cnt <= div_cnt + DIV_W'(1);
               end
            end
            DATA: begin
               if (div_done) begin
                  div_cnt <= '0;
                  if (bit_cnt == 3'd7) begin
                     tx    <= 1'b1;
                     state <= STOP;
                  end else begin
                     shift_reg <= shift_reg >> 1;
                     bit_cnt   <= bit_cnt + 3'd1;
                     tx        <= shift_reg[1];
                  end
               end else begin
                  div_cnt <= div_cnt + DIV_W'(1);
               end
            end
            STOP: begin
               if (div_done) begin
                  div_cnt <= '0;
                  if (pop) begin
                     shift_reg <= mem[rd_ptr];
                     tx        <= 1'b0;
                     state     <= START;
                  end else begin
                     tx    <= 1'b1;
                     state <= IDLE;
                  end
               end else begin
                  div_cnt <= div_cnt + DIV_W'(1);
               end
            end
            default: begin
               tx    <= 1'b1;
               state <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_lite16_uart_tx.sv
// Bench for lite16_uart_tx: bus vector table, frame decoder against a byte scoreboard, timing sequences.
module tb_lite16_uart_tx;
   localparam int unsigned DIV   = 4;
   localparam int unsigned DEPTH = 4;
   localparam logic [15:0] BASE  = 16'hFF00;
   localparam logic [15:0] CTRL  = 16'hFF01;

   typedef struct {
      logic        we;
      logic [15:0] addr;
      logic [15:0] data;
      logic [15:0] exp_rd;
      logic        exp_busy;
      logic        exp_full;
      bit          push_exp;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        tx;
   logic        busy;
   logic        fifo_full;
   int          errors = 0;
   int          checks = 0;
   int unsigned cyc = 0;
   logic [7:0]  sb_q [$];

   lite16_uart_tx_if bus_if ();

   lite16_uart_tx #(.CLK_DIV(DIV), .FIFO_DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus_if),
      .tx        (tx),
      .busy      (busy),
      .fifo_full (fifo_full)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic bus_wr(input logic [15:0] a, input logic [15:0] d, output int unsigned edge_cyc);
      @(negedge clk);
      bus_if.wr_en   = 1'b1;
      bus_if.addr    = a;
      bus_if.wr_data = d;
      @(posedge clk);
      #1;
      edge_cyc       = cyc;
      bus_if.wr_en   = 1'b0;
      bus_if.addr    = 16'h0000;
      bus_if.wr_data = 16'h0000;
   endtask

   task automatic wait_idle(input string name, input int unsigned limit, output int unsigned fall_cyc);
      int unsigned n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (busy !== 1'b0 && n < limit);
      fall_cyc = cyc;
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL %s timeout: busy=%b after %0d cycles, required 0", name, busy, n);
      end
   endtask

   // Frame decoder: samples each bit mid-period; a frame crossing a reset is discarded.
   logic [9:0] mon_fr;
   bit         mon_abort;
   logic [7:0] mon_exp;
   initial begin
      forever begin
         @(negedge clk);
         if (rst === 1'b1 && tx === 1'b0) begin
            mon_abort = 1'b0;
            mon_fr    = '0;
            for (int c = 1; c < 10 * DIV; c++) begin
               @(negedge clk);
               if (rst !== 1'b1) mon_abort = 1'b1;
               if (c % DIV == DIV / 2) mon_fr[c / DIV] = tx;
            end
            if (!mon_abort) begin
               checks++;
               if (sb_q.size() == 0) begin
                  errors++;
                  $display("FAIL frame: got unexpected frame %b, required none", mon_fr);
               end else begin
                  mon_exp = sb_q.pop_front();
                  if (mon_fr !== {1'b1, mon_exp, 1'b0}) begin
                     errors++;
                     $display("FAIL frame: got %b required %b", mon_fr, {1'b1, mon_exp, 1'b0});
                  end
               end
            end
         end
      end
   end

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation did not complete, got timeout required finish");
      errors++;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1, "watchdog");
   end

   vec_t        vecs [12];
   int unsigned t0, t1;
   logic [9:0]  exp_fr;
   logic        e_tx;
   int          lows;

   initial begin
      // Overflow/status sequence from idle-empty, CLK_DIV=4: byte 1 pops at the 2nd edge.
      vecs[0]  = '{1'b1, BASE,          16'h0001, 16'h0000, 1'b0, 1'b0, 1'b1};
      vecs[1]  = '{1'b1, BASE,          16'h0002, 16'h0000, 1'b1, 1'b0, 1'b1};
      vecs[2]  = '{1'b1, BASE,          16'h0003, 16'h0000, 1'b1, 1'b0, 1'b1};
      vecs[3]  = '{1'b1, BASE,          16'h0004, 16'h0000, 1'b1, 1'b0, 1'b1};
      vecs[4]  = '{1'b1, BASE,          16'h0005, 16'h0000, 1'b1, 1'b0, 1'b1};
      vecs[5]  = '{1'b1, BASE,          16'h0006, 16'h0000, 1'b1, 1'b1, 1'b0};
      vecs[6]  = '{1'b0, CTRL,          16'h0000, 16'h0007, 1'b1, 1'b1, 1'b0};
      vecs[7]  = '{1'b1, CTRL,          16'h0004, 16'h0007, 1'b1, 1'b1, 1'b0};
      vecs[8]  = '{1'b0, CTRL,          16'h0000, 16'h0003, 1'b1, 1'b1, 1'b0};
      vecs[9]  = '{1'b0, BASE,          16'h0000, 16'h0000, 1'b1, 1'b1, 1'b0};
      vecs[10] = '{1'b0, 16'hFF02,      16'h0000, 16'h0000, 1'b1, 1'b1, 1'b0};
      vecs[11] = '{1'b0, 16'h0000,      16'h0000, 16'h0000, 1'b1, 1'b1, 1'b0};

      rst            = 1'b0;
      bus_if.wr_en   = 1'b0;
      bus_if.addr    = CTRL;
      bus_if.wr_data = 16'h0000;
      repeat (3) @(posedge clk);
      @(negedge clk);
      #1;
      chk("reset tx", 32'(tx), 32'd1);
      chk("reset busy", 32'(busy), 32'd0);
      chk("reset fifo_full", 32'(fifo_full), 32'd0);
      chk("reset status", 32'(bus_if.rd_data), 32'h0);
      rst         = 1'b1;
      bus_if.addr = 16'h0000;
      repeat (2) @(posedge clk);

      // Single frame 8'hA5: exact waveform and busy window.
      sb_q.push_back(8'hA5);
      bus_wr(BASE, 16'h00A5, t0);
      exp_fr = {1'b1, 8'hA5, 1'b0};
      for (int j = 0; j <= 10 * DIV + 1; j++) begin
         @(negedge clk);
         e_tx = (j >= 1 && j <= 10 * DIV) ? exp_fr[(j - 1) / DIV] : 1'b1;
         chk($sformatf("a5 tx cycle %0d", j), 32'(tx), 32'(e_tx));
         chk($sformatf("a5 busy cycle %0d", j), 32'(busy), (j <= 10 * DIV) ? 32'd1 : 32'd0);
      end

      // Three back-to-back frames: busy for 3 frames plus one cycle of pop latency.
      sb_q.push_back(8'h01);
      sb_q.push_back(8'h02);
      sb_q.push_back(8'h03);
      bus_wr(BASE, 16'h0001, t0);
      bus_wr(BASE, 16'h0002, t1);
      bus_wr(BASE, 16'h0003, t1);
      wait_idle("b2b", 400, t1);
      chk("b2b busy cycles", t1 - t0, 32'(30 * DIV + 1));

      // Upper data byte ignored; store to an unmapped address pushes nothing.
      sb_q.push_back(8'h42);
      bus_wr(BASE, 16'h1242, t0);
      wait_idle("hi byte", 200, t1);
      bus_wr(BASE + 16'd2, 16'h0055, t0);
      @(negedge clk);
      chk("unmapped store busy", 32'(busy), 32'd0);
      @(negedge clk);
      chk("unmapped store tx", 32'(tx), 32'd1);
      repeat (3) @(posedge clk);

      // Overflow/status table.
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         bus_if.wr_en   = vecs[i].we;
         bus_if.addr    = vecs[i].addr;
         bus_if.wr_data = vecs[i].data;
         if (vecs[i].push_exp) sb_q.push_back(vecs[i].data[7:0]);
         #1;
         chk($sformatf("vec%0d rd_data", i), 32'(bus_if.rd_data), 32'(vecs[i].exp_rd));
         chk($sformatf("vec%0d busy", i), 32'(busy), 32'(vecs[i].exp_busy));
         chk($sformatf("vec%0d fifo_full", i), 32'(fifo_full), 32'(vecs[i].exp_full));
      end
      @(negedge clk);
      bus_if.wr_en = 1'b0;
      bus_if.addr  = 16'h0000;
      wait_idle("overflow drain", 800, t1);
      bus_if.addr = CTRL;
      #1;
      chk("status after drain", 32'(bus_if.rd_data), 32'h0);
      bus_if.addr = 16'h0000;

      // Reset during DATA bit 3 with two bytes queued: frame aborted, queue discarded.
      bus_wr(BASE, 16'h0011, t0);
      bus_wr(BASE, 16'h0022, t1);
      bus_wr(BASE, 16'h0033, t1);
      repeat (16) @(posedge clk);
      @(negedge clk);
      #1;
      chk("pre-reset busy", 32'(busy), 32'd1);
      rst         = 1'b0;
      bus_if.addr = CTRL;
      @(negedge clk);
      #1;
      chk("mid-frame reset tx", 32'(tx), 32'd1);
      chk("mid-frame reset busy", 32'(busy), 32'd0);
      chk("mid-frame reset fifo_full", 32'(fifo_full), 32'd0);
      chk("mid-frame reset status", 32'(bus_if.rd_data), 32'h0);
      rst         = 1'b1;
      bus_if.addr = 16'h0000;
      lows = 0;
      for (int k = 0; k < 150; k++) begin
         @(negedge clk);
         if (tx !== 1'b1) lows++;
      end
      chk("tx low cycles after reset", 32'(lows), 32'd0);
      chk("busy after reset", 32'(busy), 32'd0);

      chk("scoreboard drained", 32'(sb_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
